// File: rtl/uart_rx_fifo_if.sv
// Byte stream and status bundle between the UART receiver FIFO and its consumer.
interface uart_rx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    data_o;
  logic          valid_o;
  logic          ready_i;
  logic          frame_err_o;
  logic          overflow_o;
  logic          clr_i;
  logic [CW-1:0] count_o;

  // Receiver side: produces bytes and status
  modport master (
    output data_o, valid_o, frame_err_o, overflow_o, count_o,
    input  ready_i, clr_i
  );

  // Consumer side: accepts bytes and clears sticky status
  modport slave (
    input  data_o, valid_o, frame_err_o, overflow_o, count_o,
    output ready_i, clr_i
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word-fall-through byte FIFO on a valid/ready stream.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_rx_fifo_if.master bus
);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned TW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  // Receiver state
  logic          rx_q1;
  logic          rx_s;
  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          frame_err_q;

  // FIFO state
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] count_q;
  logic          valid_q;
  logic [7:0]    data_q;
  logic          overflow_q;

  // Combinational helpers
  logic          timer_done_c;
  logic          push_c;
  logic          pop_c;
  logic          full_c;
  logic          push_ok_c;
  logic          ovf_set_c;
  logic [AW:0]   wr_ptr_n;
  logic [AW:0]   rd_ptr_n;
  logic [CW-1:0] count_n;
  logic [CW-1:0] remain_c;
  logic [7:0]    data_n;

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  assign timer_done_c = (timer == TW'(CLKS_PER_BIT - 1));
  // A good stop bit pushes the assembled byte on the sample edge itself
  assign push_c       = (state == STOP) && timer_done_c && rx_s;

  // Frame decoder: start qualification at mid-bit, 8 data bits LSB first, stop check
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (timer == TW'(HALF - 1)) begin
            timer <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (timer_done_c) begin
            timer   <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (timer_done_c) begin
            timer <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO next-state: a pop frees a slot for a same-cycle push even when full
  always_comb begin
    pop_c     = valid_q && bus.ready_i;
    full_c    = (count_q == CW'(FIFO_DEPTH));
    push_ok_c = push_c && (!full_c || pop_c);
    ovf_set_c = push_c && !push_ok_c;
    wr_ptr_n  = wr_ptr + CW'(push_ok_c);
    rd_ptr_n  = rd_ptr + CW'(pop_c);
    count_n   = CW'(wr_ptr_n - rd_ptr_n);
    remain_c  = count_q - CW'(pop_c);
    data_n    = data_q;
    if (push_ok_c && (remain_c == '0)) begin
      data_n = shift;
    end else if (count_n != '0) begin
      data_n = mem[rd_ptr_n[AW-1:0]];
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr[AW-1:0]] <= shift;
  end

  // FIFO pointers, registered head byte, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      count_q <= count_n;
      valid_q <= (count_n != '0);
      data_q  <= data_n;
      if (ovf_set_c) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.frame_err_o = frame_err_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.count_o     = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frame table plus multi-cycle corner sequences.
module tb_uart_rx_fifo;
  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int err_cnt = 0;
  logic [7:0] rxq[$];

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    int         exp_push;
    int         exp_err;
  } tv_t;

  tv_t tv [6];

  // Record every accepted byte and every frame-error cycle
  always @(negedge clk) begin
    if (!rst && bus.valid_o && bus.ready_i) rxq.push_back(bus.data_o);
    if (!rst && bus.frame_err_o) err_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_rx(input string name, input logic [7:0] exp);
    chk({name, "_avail"}, 32'(rxq.size() > 0), 32'd1);
    if (rxq.size() > 0) chk(name, 32'(rxq.pop_front()), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic drain();
    bus.ready_i = 1'b1;
    repeat (DEPTH + 2) tick();
    bus.ready_i = 1'b0;
  endtask

  initial begin
    int e0;
    tv[0] = '{8'hA5, 1'b1, 1, 0};
    tv[1] = '{8'h00, 1'b1, 1, 0};
    tv[2] = '{8'hFF, 1'b1, 1, 0};
    tv[3] = '{8'h80, 1'b1, 1, 0};
    tv[4] = '{8'h3C, 1'b0, 0, 1};
    tv[5] = '{8'h11, 1'b1, 1, 0};

    rst = 1'b1;
    rx = 1'b1;
    bus.ready_i = 1'b0;
    bus.clr_i = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_data", 32'(bus.data_o), 0);
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_ovf", 32'(bus.overflow_o), 0);
    chk("rst_ferr", 32'(bus.frame_err_o), 0);
    rst = 1'b0;
    idle(4);

    // Exact latency: stop sample lands on edge 155 after the start bit is driven
    bus.ready_i = 1'b1;
    rxq.delete();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (154) tick();
        chk("t1_valid_early", 32'(bus.valid_o), 0);
        tick();
        chk("t1_valid", 32'(bus.valid_o), 1);
        chk("t1_data", 32'(bus.data_o), 32'hA5);
        chk("t1_count1", 32'(bus.count_o), 1);
        tick();
        chk("t1_count0", 32'(bus.count_o), 0);
        chk("t1_valid_off", 32'(bus.valid_o), 0);
      end
    join
    idle(CPB);
    chk_rx("t1_byte", 8'hA5);

    // Frame table with ready held high
    for (int i = 0; i < 6; i++) begin
      rxq.delete();
      e0 = err_cnt;
      send_frame(tv[i].tx, tv[i].stop);
      idle(2 * CPB);
      chk($sformatf("tv%0d_err", i), 32'(err_cnt - e0), 32'(tv[i].exp_err));
      chk($sformatf("tv%0d_n", i), 32'(rxq.size()), 32'(tv[i].exp_push));
      if (tv[i].exp_push > 0) chk_rx($sformatf("tv%0d_byte", i), tv[i].tx);
    end

    // Short low glitch aborts in START
    rxq.delete();
    e0 = err_cnt;
    rx = 1'b0;
    repeat (3) tick();
    idle(3 * CPB);
    chk("t2_valid", 32'(bus.valid_o), 0);
    chk("t2_n", 32'(rxq.size()), 0);
    chk("t2_err", 32'(err_cnt - e0), 0);

    // Bad stop bit followed by a long break, then recovery
    rxq.delete();
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40 * CPB) tick();
    chk("t3_err", 32'(err_cnt - e0), 1);
    chk("t3_count", 32'(bus.count_o), 0);
    chk("t3_n", 32'(rxq.size()), 0);
    idle(CPB);
    send_frame(8'h11, 1'b1);
    idle(CPB);
    chk("t3_n2", 32'(rxq.size()), 1);
    chk_rx("t3_byte", 8'h11);

    // Overflow with consumer stalled
    bus.ready_i = 1'b0;
    rxq.delete();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    idle(CPB);
    chk("t4_count", 32'(bus.count_o), 4);
    chk("t4_ovf", 32'(bus.overflow_o), 1);
    chk("t4_head", 32'(bus.data_o), 1);
    drain();
    chk("t4_n", 32'(rxq.size()), 4);
    for (int i = 1; i <= 4; i++) chk_rx($sformatf("t4_b%0d", i), 8'(i));
    chk("t4_ovf_sticky", 32'(bus.overflow_o), 1);
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    chk("t4_ovf_clr", 32'(bus.overflow_o), 0);

    // Full FIFO, pop coincides with the push edge
    rxq.delete();
    for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b1);
    idle(CPB);
    chk("t5_full", 32'(bus.count_o), 4);
    fork
      send_frame(8'h25, 1'b1);
      begin
        repeat (154) tick();
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
      end
    join
    idle(CPB);
    chk("t5_count", 32'(bus.count_o), 4);
    chk("t5_ovf", 32'(bus.overflow_o), 0);
    chk("t5_head", 32'(bus.data_o), 32'h22);
    chk_rx("t5_b0", 8'h21);
    drain();
    for (int i = 0; i < 4; i++) chk_rx($sformatf("t5_b%0d", i + 1), 8'h22 + 8'(i));
    chk("t5_empty", 32'(bus.count_o), 0);

    // Reset in the middle of a frame
    rxq.delete();
    send_frame(8'h77, 1'b1);
    idle(CPB);
    chk("t6_pre_count", 32'(bus.count_o), 1);
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) tick();
    rst = 1'b1;
    tick();
    chk("t6_valid", 32'(bus.valid_o), 0);
    chk("t6_data", 32'(bus.data_o), 0);
    chk("t6_count", 32'(bus.count_o), 0);
    chk("t6_ovf", 32'(bus.overflow_o), 0);
    chk("t6_ferr", 32'(bus.frame_err_o), 0);
    rst = 1'b0;
    idle(2 * CPB);
    bus.ready_i = 1'b1;
    send_frame(8'h5A, 1'b1);
    idle(CPB);
    chk("t6_n", 32'(rxq.size()), 1);
    chk_rx("t6_byte", 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
